// File: rtl/dvsd_mul_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package dvsd_mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPW   = 8;
  localparam int PRODW = 16;
endpackage

// File: rtl/dvsd_8216m3.sv
// 8x8 unsigned multiplier datapath with bit-level ports; purely combinational.
module dvsd_8216m3 (
  input  logic a0, a1, a2, a3, a4, a5, a6, a7,
  input  logic b0, b1, b2, b3, b4, b5, b6, b7,
  output logic m0, m1, m2, m3, m4, m5, m6, m7,
  output logic m8, m9, m10, m11, m12, m13, m14, m15
);
  logic [7:0]  a_vec;
  logic [7:0]  b_vec;
  logic [15:0] m_vec;

  assign a_vec = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign b_vec = {b7, b6, b5, b4, b3, b2, b1, b0};
  assign m_vec = 16'(a_vec) * 16'(b_vec);

  assign {m15, m14, m13, m12, m11, m10, m9, m8} = m_vec[15:8];
  assign {m7, m6, m5, m4, m3, m2, m1, m0}       = m_vec[7:0];
endmodule

// File: rtl/dvsd_rr_arb.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module dvsd_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/dvsd_mul_arbiter.sv
// Shares one 8x8 multiplier among NREQ requesters with round-robin arbitration.
// state | meaning
// IDLE  | no operation in flight; accepting requests
// MUL   | operands held on the multiplier, counting MUL_LAT cycles
// RESP  | product registered and offered; accepts next request on rsp_ready
module dvsd_mul_arbiter
  import dvsd_mul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [PRODW-1:0]    rsp_prod,
  input  logic                rsp_ready,
  output logic                busy
);
  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [3:0]       cnt;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic [PRODW-1:0] prod;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             accept_win;
  logic             accept;

  dvsd_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  dvsd_8216m3 u_mul (
    .a0(op_a[0]), .a1(op_a[1]), .a2(op_a[2]), .a3(op_a[3]),
    .a4(op_a[4]), .a5(op_a[5]), .a6(op_a[6]), .a7(op_a[7]),
    .b0(op_b[0]), .b1(op_b[1]), .b2(op_b[2]), .b3(op_b[3]),
    .b4(op_b[4]), .b5(op_b[5]), .b6(op_b[6]), .b7(op_b[7]),
    .m0(prod[0]),   .m1(prod[1]),   .m2(prod[2]),   .m3(prod[3]),
    .m4(prod[4]),   .m5(prod[5]),   .m6(prod[6]),   .m7(prod[7]),
    .m8(prod[8]),   .m9(prod[9]),   .m10(prod[10]), .m11(prod[11]),
    .m12(prod[12]), .m13(prod[13]), .m14(prod[14]), .m15(prod[15])
  );

  // A finished response is retired in the same cycle the next request is taken.
  assign accept_win = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign req_ready  = accept_win ? grant : '0;
  assign accept     = |req_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            op_a      <= req_a[int'(win_idx)*OPW +: OPW];
            op_b      <= req_b[int'(win_idx)*OPW +: OPW];
            id        <= win_idx;
            ptr       <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            cnt       <= 4'(MUL_LAT);
            rsp_valid <= 1'b0;
            state     <= MUL;
          end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == 4'd1) begin
            rsp_prod  <= prod;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
